// File: rtl/nihilist_stream_cipher_if.sv
// Byte-stream and key-load bundle for nihilist_stream_cipher.
// Port summary (names keep their producer/consumer direction affixes):
//   key load : i_w_key_we, i_w_key_char[7:0], i_w_key_clear
//   input    : i_w_mode, i_w_in_valid, i_w_in_data[7:0], i_w_in_last -> o_r_in_ready
//   output   : o_r_out_valid, o_r_out_data[7:0], o_r_out_last <- i_w_out_ready
//   status   : o_r_key_len, o_r_busy, o_r_err
// The master modport is the byte source/sink side; the slave modport is the cipher.
interface nihilist_stream_cipher_if #(
    parameter int p_key_max_length = 8
);
    localparam int KEY_LEN_W = $clog2(p_key_max_length + 1);

    logic                 i_w_key_we;
    logic [7:0]           i_w_key_char;
    logic                 i_w_key_clear;
    logic                 i_w_mode;
    logic                 i_w_in_valid;
    logic [7:0]           i_w_in_data;
    logic                 i_w_in_last;
    logic                 o_r_in_ready;
    logic                 o_r_out_valid;
    logic [7:0]           o_r_out_data;
    logic                 o_r_out_last;
    logic                 i_w_out_ready;
    logic [KEY_LEN_W-1:0] o_r_key_len;
    logic                 o_r_busy;
    logic                 o_r_err;

    modport master (
        output i_w_key_we, i_w_key_char, i_w_key_clear, i_w_mode,
        output i_w_in_valid, i_w_in_data, i_w_in_last, i_w_out_ready,
        input  o_r_in_ready, o_r_out_valid, o_r_out_data, o_r_out_last,
        input  o_r_key_len, o_r_busy, o_r_err
    );

    modport slave (
        input  i_w_key_we, i_w_key_char, i_w_key_clear, i_w_mode,
        input  i_w_in_valid, i_w_in_data, i_w_in_last, i_w_out_ready,
        output o_r_in_ready, o_r_out_valid, o_r_out_data, o_r_out_last,
        output o_r_key_len, o_r_busy, o_r_err
    );
endinterface

// File: rtl/nihilist_stream_cipher.sv
// Streaming Nihilist cipher over the Polybius square DANIE/LBCFG/HKMOP/QRSTU/VWXYZ
// (code = row*10 + col). The key is loaded one character at a time; text flows one
// byte per valid/ready beat through a single output register stage.
// Ports: i_w_clk (rising edge), i_w_rst (async, active high), bus (slave modport of
// nihilist_stream_cipher_if carrying key load, input stream, output stream, status).
module nihilist_stream_cipher #(
    parameter int p_key_max_length = 8
) (
    input logic                     i_w_clk,
    input logic                     i_w_rst,
    nihilist_stream_cipher_if.slave bus
);
    localparam int KLW = $clog2(p_key_max_length + 1);
    localparam int KPW = (p_key_max_length > 1) ? $clog2(p_key_max_length) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    // Letter -> square code; bit 8 flags a letter. Lowercase folds, J shares I.
    function automatic logic [8:0] letter_code(input logic [7:0] ch);
        logic [7:0] up_v;
        logic [8:0] res_v;
        if ((ch >= 8'h61) && (ch <= 8'h7a)) begin
            up_v = ch - 8'h20;
        end else begin
            up_v = ch;
        end
        case (up_v)
            8'h41: res_v = {1'b1, 8'd12};  8'h42: res_v = {1'b1, 8'd22};
            8'h43: res_v = {1'b1, 8'd23};  8'h44: res_v = {1'b1, 8'd11};
            8'h45: res_v = {1'b1, 8'd15};  8'h46: res_v = {1'b1, 8'd24};
            8'h47: res_v = {1'b1, 8'd25};  8'h48: res_v = {1'b1, 8'd31};
            8'h49, 8'h4a: res_v = {1'b1, 8'd14};
            8'h4b: res_v = {1'b1, 8'd32};  8'h4c: res_v = {1'b1, 8'd21};
            8'h4d: res_v = {1'b1, 8'd33};  8'h4e: res_v = {1'b1, 8'd13};
            8'h4f: res_v = {1'b1, 8'd34};  8'h50: res_v = {1'b1, 8'd35};
            8'h51: res_v = {1'b1, 8'd41};  8'h52: res_v = {1'b1, 8'd42};
            8'h53: res_v = {1'b1, 8'd43};  8'h54: res_v = {1'b1, 8'd44};
            8'h55: res_v = {1'b1, 8'd45};  8'h56: res_v = {1'b1, 8'd51};
            8'h57: res_v = {1'b1, 8'd52};  8'h58: res_v = {1'b1, 8'd53};
            8'h59: res_v = {1'b1, 8'd54};  8'h5a: res_v = {1'b1, 8'd55};
            default: res_v = {1'b0, 8'd0};
        endcase
        return res_v;
    endfunction

    // Square code -> uppercase letter; bit 8 flags a valid code (row 1-5, col 1-5).
    function automatic logic [8:0] code_letter(input logic [7:0] d);
        logic [8:0] res_v;
        case (d)
            8'd11: res_v = {1'b1, 8'h44};  8'd12: res_v = {1'b1, 8'h41};
            8'd13: res_v = {1'b1, 8'h4e};  8'd14: res_v = {1'b1, 8'h49};
            8'd15: res_v = {1'b1, 8'h45};  8'd21: res_v = {1'b1, 8'h4c};
            8'd22: res_v = {1'b1, 8'h42};  8'd23: res_v = {1'b1, 8'h43};
            8'd24: res_v = {1'b1, 8'h46};  8'd25: res_v = {1'b1, 8'h47};
            8'd31: res_v = {1'b1, 8'h48};  8'd32: res_v = {1'b1, 8'h4b};
            8'd33: res_v = {1'b1, 8'h4d};  8'd34: res_v = {1'b1, 8'h4f};
            8'd35: res_v = {1'b1, 8'h50};  8'd41: res_v = {1'b1, 8'h51};
            8'd42: res_v = {1'b1, 8'h52};  8'd43: res_v = {1'b1, 8'h53};
            8'd44: res_v = {1'b1, 8'h54};  8'd45: res_v = {1'b1, 8'h55};
            8'd51: res_v = {1'b1, 8'h56};  8'd52: res_v = {1'b1, 8'h57};
            8'd53: res_v = {1'b1, 8'h58};  8'd54: res_v = {1'b1, 8'h59};
            8'd55: res_v = {1'b1, 8'h5a};
            default: res_v = {1'b0, 8'd0};
        endcase
        return res_v;
    endfunction

    state_t         state_r, state_s;
    logic           mode_r;
    logic [KPW-1:0] kp_r;
    logic [KLW-1:0] key_len_r;
    logic [7:0]     key_mem_r [2**KPW];
    logic           err_r;
    logic           out_valid_r, out_last_r;
    logic [7:0]     out_data_r;

    logic           busy_s, in_ready_s, accept_s, cur_mode_s;
    logic           key_ok_s, in_ok_s, dec_ok_s;
    logic [7:0]     key_code_s, in_code_s, dec_char_s, cur_key_s, diff_s, result_s;
    logic [KLW-1:0] kp_ext_s, key_last_s;

    assign busy_s     = (state_r == S_RUN);
    assign in_ready_s = (!out_valid_r || bus.i_w_out_ready) && (key_len_r != {KLW{1'b0}});
    assign accept_s   = bus.i_w_in_valid && in_ready_s;
    assign kp_ext_s   = KLW'(kp_r);
    assign key_last_s = key_len_r - KLW'(1);

    // Cipher datapath: mode is taken live on the first beat, latched afterwards.
    always_comb begin
        {key_ok_s, key_code_s} = letter_code(bus.i_w_key_char);
        {in_ok_s, in_code_s}   = letter_code(bus.i_w_in_data);
        cur_key_s              = key_mem_r[kp_r];
        diff_s                 = bus.i_w_in_data - cur_key_s;
        {dec_ok_s, dec_char_s} = code_letter(diff_s);
        if (state_r == S_IDLE) begin
            cur_mode_s = bus.i_w_mode;
        end else begin
            cur_mode_s = mode_r;
        end
        if (cur_mode_s) begin
            if (dec_ok_s) begin
                result_s = dec_char_s;
            end else begin
                result_s = diff_s;
            end
        end else begin
            if (in_ok_s) begin
                result_s = in_code_s + cur_key_s;
            end else begin
                result_s = bus.i_w_in_data + cur_key_s;
            end
        end
    end

    // Message FSM next state: a single beat carrying last never leaves S_IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && !bus.i_w_in_last) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && bus.i_w_in_last) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RUN;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register and per-message mode latch.
    always_ff @(posedge i_w_clk or posedge i_w_rst) begin
        if (i_w_rst) begin
            state_r <= S_IDLE;
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s && (state_r == S_IDLE)) begin
                mode_r <= bus.i_w_mode;
            end
        end
    end

    // Key storage; key operations during a message are refused and flagged.
    always_ff @(posedge i_w_clk or posedge i_w_rst) begin
        if (i_w_rst) begin
            key_len_r <= {KLW{1'b0}};
            err_r     <= 1'b0;
            for (int i = 0; i < 2**KPW; i++) begin
                key_mem_r[i] <= 8'd0;
            end
        end else if (busy_s && (bus.i_w_key_we || bus.i_w_key_clear)) begin
            err_r <= 1'b1;
        end else if (bus.i_w_key_clear) begin
            key_len_r <= {KLW{1'b0}};
            err_r     <= 1'b0;
        end else if (bus.i_w_key_we) begin
            if (key_len_r == KLW'(p_key_max_length)) begin
                err_r <= 1'b1;
            end else begin
                key_mem_r[key_len_r[KPW-1:0]] <= key_ok_s ? key_code_s : 8'd0;
                key_len_r                     <= key_len_r + KLW'(1);
                if (!key_ok_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    // Key pointer: wraps at key_len and restarts after each last beat.
    always_ff @(posedge i_w_clk or posedge i_w_rst) begin
        if (i_w_rst) begin
            kp_r <= {KPW{1'b0}};
        end else if (accept_s) begin
            if (bus.i_w_in_last || (kp_ext_s == key_last_s)) begin
                kp_r <= {KPW{1'b0}};
            end else begin
                kp_r <= kp_r + KPW'(1);
            end
        end
    end

    // Output register stage; data and last hold while the sink stalls.
    always_ff @(posedge i_w_clk or posedge i_w_rst) begin
        if (i_w_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_last_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_last_r  <= bus.i_w_in_last;
        end else if (bus.i_w_out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.o_r_in_ready  = in_ready_s;
    assign bus.o_r_out_valid = out_valid_r;
    assign bus.o_r_out_data  = out_data_r;
    assign bus.o_r_out_last  = out_last_r;
    assign bus.o_r_key_len   = key_len_r;
    assign bus.o_r_busy      = busy_s;
    assign bus.o_r_err       = err_r;
endmodule
